// File: rtl/parking_multi_gate_ctrl_pkg.sv
// Shared lane state encodings and default sizing for the multi-gate parking controller.
package parking_pkg;

    typedef enum logic [1:0] {
        ENTRY_IDLE   = 2'd0,
        ENTRY_OPEN   = 2'd1,
        ENTRY_LOCKED = 2'd2
    } entry_state_t;

    typedef enum logic {
        EXIT_IDLE = 1'b0,
        EXIT_OPEN = 1'b1
    } exit_state_t;

    localparam int DEF_NUM_LANES        = 2;
    localparam int DEF_COUNT_W          = 6;
    localparam int DEF_PASS_W           = 8;
    localparam int DEF_GATE_OPEN_CYCLES = 4;
    localparam int DEF_MAX_FAILS        = 3;
    localparam int DEF_LOCKOUT_CYCLES   = 16;

endpackage

// File: rtl/parking_lane_fsm.sv
// One entry/exit lane pair: gate timers, wrong-code counter and lockout.
// Slot and exit decisions come from the top; this block only reports candidates.
module parking_lane_fsm
    import parking_pkg::*;
#(
    parameter int GATE_OPEN_CYCLES = DEF_GATE_OPEN_CYCLES,
    parameter int MAX_FAILS        = DEF_MAX_FAILS,
    parameter int LOCKOUT_CYCLES   = DEF_LOCKOUT_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enter_req,
    input  logic code_ok,
    input  logic entry_grant,
    input  logic exit_req,
    input  logic exit_accept,
    output logic entry_cand,
    output logic exit_cand,
    output logic entry_gate_open,
    output logic exit_gate_open,
    output logic entry_denied,
    output logic lane_locked
);

    localparam int MAX_T  = (GATE_OPEN_CYCLES > LOCKOUT_CYCLES) ? GATE_OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W  = $clog2(MAX_T + 1);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);

    entry_state_t      entry_state;
    exit_state_t       exit_state;
    logic [TMR_W-1:0]  entry_tmr;
    logic [TMR_W-1:0]  exit_tmr;
    logic [FAIL_W-1:0] fail_cnt;

    // Only idle lanes with a valid code compete for slots; busy lanes ignore requests.
    assign entry_cand = (entry_state == ENTRY_IDLE) && enter_req && code_ok;
    assign exit_cand  = (exit_state == EXIT_IDLE) && exit_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entry_state     <= ENTRY_IDLE;
            entry_tmr       <= '0;
            fail_cnt        <= '0;
            entry_gate_open <= 1'b0;
            entry_denied    <= 1'b0;
            lane_locked     <= 1'b0;
        end else begin
            entry_denied <= 1'b0;
            case (entry_state)
                ENTRY_IDLE: begin
                    if (enter_req) begin
                        if (code_ok && entry_grant) begin
                            entry_state     <= ENTRY_OPEN;
                            entry_gate_open <= 1'b1;
                            entry_tmr       <= TMR_W'(GATE_OPEN_CYCLES - 1);
                            fail_cnt        <= '0;
                        end else if (code_ok) begin
                            entry_denied <= 1'b1;
                        end else begin
                            entry_denied <= 1'b1;
                            if (fail_cnt == FAIL_W'(MAX_FAILS - 1)) begin
                                entry_state <= ENTRY_LOCKED;
                                lane_locked <= 1'b1;
                                entry_tmr   <= TMR_W'(LOCKOUT_CYCLES - 1);
                                fail_cnt    <= '0;
                            end else begin
                                fail_cnt <= fail_cnt + 1'b1;
                            end
                        end
                    end
                end
                ENTRY_OPEN: begin
                    if (entry_tmr == '0) begin
                        entry_state     <= ENTRY_IDLE;
                        entry_gate_open <= 1'b0;
                    end else begin
                        entry_tmr <= entry_tmr - 1'b1;
                    end
                end
                ENTRY_LOCKED: begin
                    if (entry_tmr == '0) begin
                        entry_state <= ENTRY_IDLE;
                        lane_locked <= 1'b0;
                    end else begin
                        entry_tmr <= entry_tmr - 1'b1;
                    end
                end
                default: begin
                    entry_state     <= ENTRY_IDLE;
                    entry_gate_open <= 1'b0;
                    lane_locked     <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exit_state     <= EXIT_IDLE;
            exit_tmr       <= '0;
            exit_gate_open <= 1'b0;
        end else begin
            case (exit_state)
                EXIT_IDLE: begin
                    if (exit_accept) begin
                        exit_state     <= EXIT_OPEN;
                        exit_gate_open <= 1'b1;
                        exit_tmr       <= TMR_W'(GATE_OPEN_CYCLES - 1);
                    end
                end
                EXIT_OPEN: begin
                    if (exit_tmr == '0) begin
                        exit_state     <= EXIT_IDLE;
                        exit_gate_open <= 1'b0;
                    end else begin
                        exit_tmr <= exit_tmr - 1'b1;
                    end
                end
                default: begin
                    exit_state     <= EXIT_IDLE;
                    exit_gate_open <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/parking_multi_gate_ctrl.sv
// Multi-lane parking controller: shared occupancy counter, lowest-lane-first slot
// and exit arbitration, and one parking_lane_fsm per entry/exit lane pair.
module parking_multi_gate_ctrl
    import parking_pkg::*;
#(
    parameter int NUM_LANES        = DEF_NUM_LANES,
    parameter int COUNT_W          = DEF_COUNT_W,
    parameter int PASS_W           = DEF_PASS_W,
    parameter int GATE_OPEN_CYCLES = DEF_GATE_OPEN_CYCLES,
    parameter int MAX_FAILS        = DEF_MAX_FAILS,
    parameter int LOCKOUT_CYCLES   = DEF_LOCKOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [PASS_W-1:0]             passcode_set,
    input  logic [COUNT_W-1:0]            max_capacity,
    input  logic [NUM_LANES-1:0]          enter_req,
    input  logic [NUM_LANES*PASS_W-1:0]   passcode_in,
    input  logic [NUM_LANES-1:0]          exit_req,
    output logic [COUNT_W-1:0]            car_count,
    output logic [NUM_LANES-1:0]          entry_gate_open,
    output logic [NUM_LANES-1:0]          exit_gate_open,
    output logic [NUM_LANES-1:0]          entry_denied,
    output logic [NUM_LANES-1:0]          lane_locked,
    output logic                          lot_full,
    output logic                          lot_empty
);

    // Wide enough for both the occupancy range and a per-cycle lane tally.
    localparam int SUM_W = ((COUNT_W > 4) ? COUNT_W : 4) + 1;

    logic [NUM_LANES-1:0] code_ok;
    logic [NUM_LANES-1:0] entry_cand;
    logic [NUM_LANES-1:0] exit_cand;
    logic [NUM_LANES-1:0] entry_grant;
    logic [NUM_LANES-1:0] exit_accept;
    logic [SUM_W-1:0]     free_slots;
    logic [SUM_W-1:0]     grant_cnt;
    logic [SUM_W-1:0]     exit_cnt;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            assign code_ok[g] = (passcode_in[g*PASS_W +: PASS_W] == passcode_set);

            parking_lane_fsm #(
                .GATE_OPEN_CYCLES (GATE_OPEN_CYCLES),
                .MAX_FAILS        (MAX_FAILS),
                .LOCKOUT_CYCLES   (LOCKOUT_CYCLES)
            ) u_lane (
                .clk             (clk),
                .reset_n         (reset_n),
                .enter_req       (enter_req[g]),
                .code_ok         (code_ok[g]),
                .entry_grant     (entry_grant[g]),
                .exit_req        (exit_req[g]),
                .exit_accept     (exit_accept[g]),
                .entry_cand      (entry_cand[g]),
                .exit_cand       (exit_cand[g]),
                .entry_gate_open (entry_gate_open[g]),
                .exit_gate_open  (exit_gate_open[g]),
                .entry_denied    (entry_denied[g]),
                .lane_locked     (lane_locked[g])
            );
        end
    endgenerate

    // Free slots come from the registered count only, so same-cycle exits never
    // make room for same-cycle entries.
    always_comb begin
        free_slots  = (max_capacity > car_count) ? SUM_W'(max_capacity - car_count) : '0;
        grant_cnt   = '0;
        exit_cnt    = '0;
        entry_grant = '0;
        exit_accept = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (entry_cand[i] && (grant_cnt < free_slots)) begin
                entry_grant[i] = 1'b1;
                grant_cnt      = grant_cnt + SUM_W'(1);
            end
            if (exit_cand[i] && (exit_cnt < SUM_W'(car_count))) begin
                exit_accept[i] = 1'b1;
                exit_cnt       = exit_cnt + SUM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            car_count <= '0;
        end else begin
            car_count <= COUNT_W'(SUM_W'(car_count) + grant_cnt - exit_cnt);
        end
    end

    assign lot_full  = (car_count >= max_capacity);
    assign lot_empty = (car_count == '0);

endmodule
